rock_motor_driver: RTL and testbench

ROCK_MOTOR_DRIVER -- requirements
Module: rock_motor_driver

---
 rtl/rock_motor_driver.sv | 142 ++++++++++++++
 tb/tb_rock_motor_driver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rock_motor_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rock_motor_driver: swings a motor FWD/REV with PWM amplitude, brakes on stop |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module rock_motor_driver #(
   parameter int unsigned TICK_DIV    = 50000,
   parameter int unsigned BRAKE_TICKS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] A,
   input  logic [3:0] F,
   output logic       pwm,
   output logic       dir,
   output logic       brake,
   output logic       half_done
);

   localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
   localparam logic [4:0]  BRAKE_LOAD = 5'(BRAKE_TICKS);
   localparam logic [3:0]  PWM_LAST   = 4'd14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FWD   = 2'd1,
      REV   = 2'd2,
      BRAKE = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [15:0] tick_cnt, tick_cnt_n;
   logic [4:0]  half_cnt, half_cnt_n;
   logic [4:0]  brake_cnt, brake_cnt_n;
   logic [3:0]  pwm_cnt, pwm_cnt_n;
   logic [3:0]  a_l, a_l_n;
   logic [3:0]  f_l, f_l_n;
   logic        pwm_n, dir_n, brake_n, half_done_n;
   logic        tick;
   logic        af_ok;

   assign tick  = (tick_cnt == TICK_LAST);
   assign af_ok = (A != 4'd0) && (F != 4'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tick_cnt  <= 16'd0;
         half_cnt  <= 5'd0;
         brake_cnt <= 5'd0;
         pwm_cnt   <= 4'd0;
         a_l       <= 4'd0;
         f_l       <= 4'd0;
         pwm       <= 1'b0;
         dir       <= 1'b0;
         brake     <= 1'b0;
         half_done <= 1'b0;
      end else begin
         state     <= state_n;
         tick_cnt  <= tick_cnt_n;
         half_cnt  <= half_cnt_n;
         brake_cnt <= brake_cnt_n;
         pwm_cnt   <= pwm_cnt_n;
         a_l       <= a_l_n;
         f_l       <= f_l_n;
         pwm       <= pwm_n;
         dir       <= dir_n;
         brake     <= brake_n;
         half_done <= half_done_n;
      end
   end

   always_comb begin
      state_n     = state;
      tick_cnt_n  = tick ? 16'd0 : tick_cnt + 16'd1;
      half_cnt_n  = half_cnt;
      brake_cnt_n = brake_cnt;
      pwm_cnt_n   = pwm_cnt;
      a_l_n       = a_l;
      f_l_n       = f_l;
      half_done_n = 1'b0;

      case (state)
         IDLE: begin
            tick_cnt_n = 16'd0;
            pwm_cnt_n  = 4'd0;
            if (af_ok) begin
               state_n    = FWD;
               a_l_n      = A;
               f_l_n      = F;
               half_cnt_n = 5'd17 - {1'b0, F};
            end
         end
         FWD, REV: begin
            pwm_cnt_n = (pwm_cnt == PWM_LAST) ? 4'd0 : pwm_cnt + 4'd1;
            if (tick) begin
               if (half_cnt == 5'd1) begin
                  // Swing boundary: the only point where A/F are sampled mid-run
                  half_done_n = 1'b1;
                  if (af_ok) begin
                     state_n    = (state == FWD) ? REV : FWD;
                     a_l_n      = A;
                     f_l_n      = F;
                     half_cnt_n = 5'd17 - {1'b0, F};
                  end else begin
                     state_n     = BRAKE;
                     brake_cnt_n = BRAKE_LOAD;
                     pwm_cnt_n   = 4'd0;
                  end
               end else begin
                  half_cnt_n = half_cnt - 5'd1;
               end
            end
         end
         BRAKE: begin
            pwm_cnt_n = 4'd0;
            if (tick) begin
               if (brake_cnt == 5'd1) begin
                  state_n = IDLE;
               end else begin
                  brake_cnt_n = brake_cnt - 5'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from next-state values so they line up with the new state
   always_comb begin
      pwm_n   = ((state_n == FWD) || (state_n == REV)) && (pwm_cnt_n < a_l_n);
      brake_n = (state_n == BRAKE);
      case (state_n)
         FWD:     dir_n = 1'b1;
         REV:     dir_n = 1'b0;
         BRAKE:   dir_n = dir;
         default: dir_n = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_rock_motor_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rock_motor_driver: directed self-checking bench, TICK_DIV=4 BRAKE_TICKS=3 |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_rock_motor_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] A;
   logic [3:0] F;
   logic       pwm, dir, brake, half_done;

   int checks   = 0;
   int failures = 0;

   rock_motor_driver #(
      .TICK_DIV   (4),
      .BRAKE_TICKS(3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .A        (A),
      .F        (F),
      .pwm      (pwm),
      .dir      (dir),
      .brake    (brake),
      .half_done(half_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts on the sample of a swing's first clock and ends on the sample of the
   // next boundary; counts pwm over the first 15 clocks and stray half_done pulses.
   task automatic swing(input int len, input int chg_at, input logic [3:0] a_new,
                        input logic [3:0] f_new, output int hi, output int hd);
      hi = int'(pwm);
      hd = 0;
      for (int i = 1; i <= len; i++) begin
         if (i == chg_at) begin
            A = a_new;
            F = f_new;
         end
         step();
         if (i < 15) hi += int'(pwm);
         if (i < len) hd += int'(half_done);
      end
   endtask

   // Runs the 12-clock brake window from the brake-entry sample to the IDLE sample.
   task automatic brake_window(input string tag, input int exp_dir);
      int bad;
      bad = 0;
      for (int i = 1; i < 12; i++) begin
         step();
         if (brake !== 1'b1 || pwm !== 1'b0 || dir !== exp_dir[0] || half_done !== 1'b0)
            bad++;
      end
      check_eq({tag, "_hold"}, bad, 0);
      step();
      check_eq({tag, "_idle_brake"}, int'(brake), 0);
      check_eq({tag, "_idle_dir"}, int'(dir), 0);
      check_eq({tag, "_idle_pwm"}, int'(pwm), 0);
   endtask

   initial begin
      int hi, hd;
      reset = 1'b1;
      A     = 4'd0;
      F     = 4'd0;
      step();
      step();
      check_eq("rst_pwm", int'(pwm), 0);
      check_eq("rst_dir", int'(dir), 0);
      check_eq("rst_brake", int'(brake), 0);
      check_eq("rst_half_done", int'(half_done), 0);

      reset = 1'b0;
      A     = 4'd7;
      F     = 4'd0;
      step();
      step();
      check_eq("idle_f0_dir", int'(dir), 0);
      check_eq("idle_f0_pwm", int'(pwm), 0);

      // A=8, F=5: 12 ticks of 4 clocks per half swing
      A = 4'd8;
      F = 4'd5;
      step();
      check_eq("fwd_entry_dir", int'(dir), 1);
      check_eq("fwd_entry_pwm", int'(pwm), 1);
      check_eq("fwd_entry_brake", int'(brake), 0);
      swing(48, 20, 4'd15, 4'd5, hi, hd);
      check_eq("duty_a8", hi, 8);
      check_eq("no_early_hd_1", hd, 0);
      check_eq("hd_at_48", int'(half_done), 1);
      check_eq("rev_dir", int'(dir), 0);
      step();
      check_eq("hd_one_clk", int'(half_done), 0);

      // REV swing runs with A=15 latched; request A=1 for the next swing
      swing(47, 19, 4'd1, 4'd5, hi, hd);
      check_eq("no_early_hd_2", hd, 0);
      check_eq("hd_rev_end", int'(half_done), 1);
      check_eq("fwd2_dir", int'(dir), 1);

      swing(48, 20, 4'd8, 4'd15, hi, hd);
      check_eq("duty_a1", hi, 1);
      check_eq("f_change_no_early_hd", hd, 0);
      check_eq("f_change_hd_48", int'(half_done), 1);
      check_eq("rev2_dir", int'(dir), 0);

      // F=15 now latched: 2 ticks = 8 clocks per swing
      swing(8, 0, 4'd0, 4'd0, hi, hd);
      check_eq("f15_no_early_hd", hd, 0);
      check_eq("f15_hd_8", int'(half_done), 1);
      check_eq("f15_dir", int'(dir), 1);

      swing(8, 3, 4'd8, 4'd0, hi, hd);
      check_eq("brk_no_early_hd", hd, 0);
      check_eq("brk_entry_hd", int'(half_done), 1);
      check_eq("brk_entry_brake", int'(brake), 1);
      check_eq("brk_entry_pwm", int'(pwm), 0);
      check_eq("brk_entry_dir", int'(dir), 1);
      brake_window("brk1", 1);
      step();
      check_eq("idle_stay_brake", int'(brake), 0);
      check_eq("idle_stay_dir", int'(dir), 0);

      // A=3, F=4: 13 ticks = 52 clocks; stop exactly at the boundary edge
      A = 4'd3;
      F = 4'd4;
      step();
      check_eq("fwd3_entry_dir", int'(dir), 1);
      swing(52, 52, 4'd3, 4'd0, hi, hd);
      check_eq("duty_a3", hi, 3);
      check_eq("f4_no_early_hd", hd, 0);
      check_eq("brk2_entry_brake", int'(brake), 1);
      check_eq("brk2_entry_dir", int'(dir), 1);
      A = 4'd3;
      F = 4'd4;
      brake_window("brk2", 1);
      step();
      check_eq("restart_after_brake_dir", int'(dir), 1);
      check_eq("restart_after_brake_pwm", int'(pwm), 1);

      // Reset mid-swing, then restart with a full-length swing
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1;
      step();
      check_eq("mid_rst_pwm", int'(pwm), 0);
      check_eq("mid_rst_dir", int'(dir), 0);
      check_eq("mid_rst_brake", int'(brake), 0);
      check_eq("mid_rst_hd", int'(half_done), 0);
      reset = 1'b0;
      step();
      check_eq("post_rst_dir", int'(dir), 1);
      swing(52, 0, 4'd0, 4'd0, hi, hd);
      check_eq("post_rst_duty", hi, 3);
      check_eq("post_rst_no_early_hd", hd, 0);
      check_eq("post_rst_hd_52", int'(half_done), 1);
      check_eq("post_rst_rev_dir", int'(dir), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
